// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler sharing one bank of T flip-flops among several requesters.
// A granted requester's mask is pulsed onto t for cnt cycles; the settled q is returned with ack.
module tff_toggle_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic [NREQ*CW-1:0]    cnt,
  input  logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      t,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

  typedef enum logic [1:0] {StIdle, StPulse, StSettle, StAck} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic              found;
  logic [PW-1:0]     sel;

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      if (!found && req[j[PW-1:0]]) begin
        found = 1'b1;
        sel   = j[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = OneHot0 << sel;
          gidx_d  = sel;
          mask_d  = mask[sel*WIDTH +: WIDTH];
          cnt_d   = cnt[sel*CW +: CW];
          state_d = (cnt_d == '0) ? StSettle : StPulse;
        end
      end
      StPulse: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StSettle;
      end
      StSettle: begin
        // q has absorbed the last toggle; capture it as the ack is raised.
        state_d = StAck;
        ack_d   = gnt_q;
        rdata_d = q;
      end
      StAck: begin
        state_d = StIdle;
        gnt_d   = '0;
        ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign t     = (state_q == StPulse) ? mask_q : '0;
  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_tff_toggle_scheduler.sv
// Directed bench for tff_toggle_scheduler with a behavioural TFF bank on the q/t loop.
module tb_tff_toggle_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] mask;
  logic [15:0] cnt;
  logic [7:0]  qb;
  logic [7:0]  t;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  tff_toggle_scheduler #(.NREQ(4), .WIDTH(8), .CW(4)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .mask  (mask),
    .cnt   (cnt),
    .q     (qb),
    .t     (t),
    .gnt   (gnt),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // External TFF bank sharing clk/rstn.
  always_ff @(posedge clk) begin
    if (!rstn) qb <= '0;
    else       qb <= qb ^ t;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    mask = '0;
    cnt  = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({gnt, ack, t, rdata, busy} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_state gnt=%b ack=%b t=%h rdata=%h busy=%b, want all zero",
               gnt, ack, t, rdata, busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      n_err++;
      $display("FAIL idle_no_req busy=%b gnt=%b, want 0/0000", busy, gnt);
    end
  endtask

  task automatic test_odd_count();
    do_reset();
    mask[7:0] = 8'h0F;
    cnt[3:0]  = 4'd3;
    req       = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL odd_gnt gnt=%b busy=%b, want 0001/1", gnt, busy);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (t !== 8'h0F || ack !== 4'b0) begin
        n_err++;
        $display("FAIL odd_pulse%0d t=%h ack=%b, want 0f/0000", k, t, ack);
      end
      tick();
    end
    n_cmp++;
    if (t !== 8'h00 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL odd_settle t=%h ack=%b, want 00/0000", t, ack);
    end
    tick();
    n_cmp++;
    if (ack !== 4'b0001 || rdata !== 8'h0F || t !== 8'h00) begin
      n_err++;
      $display("FAIL odd_ack ack=%b rdata=%h t=%h, want 0001/0f/00", ack, rdata, t);
    end
    req = '0;
    tick();
    n_cmp++;
    if (ack !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || rdata !== 8'h0F) begin
      n_err++;
      $display("FAIL odd_after ack=%b gnt=%b busy=%b rdata=%h, want 0000/0000/0/0f",
               ack, gnt, busy, rdata);
    end
  endtask

  task automatic test_even_count();
    do_reset();
    mask[7:0] = 8'hFF;
    cnt[3:0]  = 4'd2;
    req       = 4'b0001;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (t !== 8'hFF || gnt !== 4'b0001) begin
        n_err++;
        $display("FAIL even_pulse%0d t=%h gnt=%b, want ff/0001", k, t, gnt);
      end
      tick();
    end
    n_cmp++;
    if (t !== 8'h00 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL even_settle t=%h ack=%b, want 00/0000", t, ack);
    end
    tick();
    n_cmp++;
    if (ack !== 4'b0001 || rdata !== 8'h00) begin
      n_err++;
      $display("FAIL even_ack ack=%b rdata=%h, want 0001/00", ack, rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_zero_count();
    do_reset();
    mask[23:16] = 8'hFF;
    cnt[11:8]   = 4'd0;
    req         = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || t !== 8'h00 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_gnt gnt=%b t=%h busy=%b, want 0100/00/1", gnt, t, busy);
    end
    tick();
    n_cmp++;
    if (ack !== 4'b0100 || t !== 8'h00 || rdata !== 8'h00) begin
      n_err++;
      $display("FAIL zero_ack ack=%b t=%h rdata=%h, want 0100/00/00", ack, t, rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int          ord[6];
    logic [7:0]  exp_q[6];
    int          w;
    ord   = '{0, 1, 2, 3, 0, 3};
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h06};
    do_reset();
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    cnt  = {4'd1, 4'd1, 4'd1, 4'd1};
    req  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (gnt === 4'b0 && w < 20);
      n_cmp++;
      if (gnt !== (4'b0001 << ord[i]) || (i > 0 && w != 2)) begin
        n_err++;
        $display("FAIL rr_gnt%0d gnt=%b wait=%0d, want %b", i, gnt, w, 4'b0001 << ord[i]);
      end
      w = 0;
      do begin
        tick();
        w++;
      end while (ack === 4'b0 && w < 20);
      n_cmp++;
      if (ack !== (4'b0001 << ord[i]) || w != 2 || rdata !== exp_q[i]) begin
        n_err++;
        $display("FAIL rr_ack%0d ack=%b lat=%0d rdata=%h, want %b/2/%h",
                 i, ack, w, rdata, 4'b0001 << ord[i], exp_q[i]);
      end
      req[ord[i]] = 1'b0;
      if (i == 3) req = 4'b1001;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mask[15:8] = 8'h3C;
    cnt[7:4]   = 4'd15;
    req        = 4'b0010;
    tick();
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (t !== 8'h3C || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_fifth_pulse t=%h gnt=%b, want 3c/0010", t, gnt);
    end
    rstn = 1'b0;
    tick();
    n_cmp++;
    if (t !== 8'h00 || gnt !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL mid_abort t=%h gnt=%b busy=%b ack=%b, want 00/0000/0/0000",
               t, gnt, busy, ack);
    end
    rstn     = 1'b1;
    cnt[7:4] = 4'd1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || t !== 8'h3C) begin
      n_err++;
      $display("FAIL mid_regrant gnt=%b t=%h, want 0010/3c", gnt, t);
    end
    tick();
    tick();
    n_cmp++;
    if (ack !== 4'b0010 || rdata !== 8'h3C) begin
      n_err++;
      $display("FAIL mid_ack ack=%b rdata=%h, want 0010/3c", ack, rdata);
    end
    req = '0;
    tick();
  endtask

  // Continues from the bank value left by test_reset_mid (q = 3c, pointer at 2).
  task automatic test_latched_inputs();
    mask[31:24] = 8'hA5;
    cnt[15:12]  = 4'd1;
    req         = 4'b1000;
    tick();
    mask[31:24] = 8'hFF;
    req         = 4'b0000;
    #1;
    n_cmp++;
    if (gnt !== 4'b1000 || t !== 8'hA5) begin
      n_err++;
      $display("FAIL latch_pulse gnt=%b t=%h, want 1000/a5", gnt, t);
    end
    tick();
    n_cmp++;
    if (t !== 8'h00) begin
      n_err++;
      $display("FAIL latch_settle t=%h, want 00", t);
    end
    tick();
    n_cmp++;
    if (ack !== 4'b1000 || rdata !== 8'h99) begin
      n_err++;
      $display("FAIL latch_ack ack=%b rdata=%h, want 1000/99", ack, rdata);
    end
    tick();
    n_cmp++;
    if (ack !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL latch_idle ack=%b gnt=%b busy=%b, want 0000/0000/0", ack, gnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_odd_count();
    test_even_count();
    test_zero_count();
    test_round_robin();
    test_reset_mid();
    test_latched_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tff_toggle_scheduler.md
Name: tff_toggle_scheduler

Overview:
- Round-robin scheduler that shares one WIDTH-bit bank of T flip-flops among NREQ requesters.
- Each granted requester supplies a toggle mask and a pulse count. The scheduler drives the bank's t inputs for that many cycles, waits one cycle for q to settle, then returns the resulting q with a one-cycle ack.
- Sits between the requesting blocks and the tff bank. It owns the bank's t vector exclusively.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the TFF bank and of each mask.
- CW, 4, width of the per-request pulse count.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous reset, active-low.
- req  input  NREQ  per-requester request level; held until ack.
- mask  input  NREQ*WIDTH  toggle mask; requester i uses bits [i*WIDTH +: WIDTH].
- cnt  input  NREQ*CW  pulse count; requester i uses bits [i*CW +: CW].
- q  input  WIDTH  current outputs of the TFF bank.
- t  output  WIDTH  toggle enables to the TFF bank.
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  one-hot completion pulse, one cycle.
- rdata  output  WIDTH  bank q captured at completion; valid while ack is high, then held.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values (rstn low at a clk edge): state=IDLE, t=0, gnt=0, ack=0, rdata=0, busy=0, rr pointer=0, internal mask/count registers=0.
- Reset mid-operation aborts the operation; t returns to 0 at that same edge and no ack is issued.
- State machine: IDLE -> PULSE -> SETTLE -> ACK -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - At the edge: register gnt, latch that requester's mask and cnt, and go to PULSE.
  - If the latched cnt is 0, go to SETTLE instead.
  - With no req, stay in IDLE.
- PULSE:
  - t = latched mask for exactly cnt consecutive cycles; the internal counter decrements each cycle.
  - On the last pulse cycle, the next state is SETTLE.
- SETTLE: t=0 for one cycle, so the bank's q reflects the final toggle.
- ACK (one cycle):
  - ack[g]=1 and rdata=q sampled at entry to ACK; t=0.
  - rr pointer = (g+1) mod NREQ.
  - At the edge: gnt clears and the state returns to IDLE.
- t is nonzero only in PULSE. Bits of t outside the mask are never set.
- Latency:
  - gnt rises 1 cycle after req is sampled in IDLE.
  - ack rises cnt+1 cycles after gnt.
  - Back-to-back grant is possible on the cycle after ACK.
- Requester protocol:
  - Hold req, mask and cnt stable from req assertion until ack is seen.
  - Deassert req on the edge where ack is sampled high.
  - A req still high in the IDLE cycle after ACK counts as a new request, at lowest priority.
- Changes to mask/cnt after grant are ignored (latched values are used). Dropping req after grant does not cancel: the operation completes and ack is still pulsed.
- Simultaneous requests are served strictly in round-robin order from the pointer, so no requester waits more than NREQ-1 operations.
- Expected result: rdata = q_at_grant XOR (cnt odd ? mask : 0).
- The bank is external. q is trusted as registered TFF outputs with the same clk/rstn.

Test Plan:
- Reset, then req[0]=1 with mask=8'h0F, cnt=3 and bank at 0 -> gnt=0001 next cycle; t=8'h0F for 3 cycles, then 0; ack[0] 4 cycles after gnt; rdata=8'h0F.
- Reset, then req[0] with mask=8'hFF, cnt=2 -> 2 pulses; rdata=8'h00; ack[0] 3 cycles after gnt.
- Reset, then req[2] with cnt=0 -> t stays 0 throughout; PULSE is skipped; ack[2] 1 cycle after gnt; rdata = q unchanged.
- Reset, then req=1111 asserted together, each held until its ack -> grants in order 0,1,2,3. Re-assert req[0] and req[3] after their acks -> next grants 0 then 3, showing the pointer wraps.
- Reset, grant req[1] with cnt=15, assert rstn=0 during the 5th pulse -> at that edge t=0, gnt=0, busy=0, and no ack[1]. After release, a new req[1] is served normally.
- Reset, grant req[3] with mask=8'hA5, cnt=1; change mask to 8'hFF and drop req during PULSE -> t=8'hA5 only; ack[3] still pulsed; rdata = previous q ^ 8'hA5.
